// File: rtl/clock_ctrl_pkg.sv
// Shared encodings, field layout and BCD limits for the clock time-setting controller.
package clock_ctrl_pkg;

    localparam int TIME_W  = 24;
    localparam int FIELD_W = 8;

    // Byte offsets of each field in 0xHHMMSS; live bits are H=[21:16], M=[14:8], S=[6:0].
    localparam int H_LSB = 16;
    localparam int M_LSB = 8;
    localparam int S_LSB = 0;

    localparam logic [FIELD_W-1:0] H_MAX  = 8'h23;
    localparam logic [FIELD_W-1:0] MS_MAX = 8'h59;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    typedef logic [TIME_W-1:0] time_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/time inputs and load/display outputs of the clock time-setting controller.
interface clock_set_ctrl_if;
    import clock_ctrl_pkg::*;

    logic        TICK;
    logic        BTN_MODE;
    logic        BTN_UP;
    logic        BTN_DOWN;
    time_t       CUR_TIME;
    logic        RUN_EN;
    logic        LOAD;
    time_t       LOAD_VAL;
    time_t       EDIT_VAL;
    logic [2:0]  BLINK_MASK;
    logic [1:0]  MODE_STATE;

    modport master (
        output TICK, BTN_MODE, BTN_UP, BTN_DOWN, CUR_TIME,
        input  RUN_EN, LOAD, LOAD_VAL, EDIT_VAL, BLINK_MASK, MODE_STATE
    );

    modport slave (
        input  TICK, BTN_MODE, BTN_UP, BTN_DOWN, CUR_TIME,
        output RUN_EN, LOAD, LOAD_VAL, EDIT_VAL, BLINK_MASK, MODE_STATE
    );

endinterface

// File: rtl/bcd_field_step.sv
// Combinational two-digit BCD increment/decrement with wrap between 00 and limit.
module bcd_field_step
    import clock_ctrl_pkg::*;
(
    input  logic [FIELD_W-1:0] val,
    input  logic [FIELD_W-1:0] limit,
    input  logic               up,
    output logic [FIELD_W-1:0] result
);

    always_comb begin
        result = val;
        if (up) begin
            if (val >= limit)
                result = '0;
            else if (val[3:0] == 4'd9)
                result = {val[7:4] + 4'd1, 4'd0};
            else
                result = {val[7:4], val[3:0] + 4'd1};
        end else begin
            // Out-of-range input also snaps to the limit so the result stays legal.
            if (val == '0 || val > limit)
                result = limit;
            else if (val[3:0] == 4'd0)
                result = {val[7:4] - 4'd1, 4'd9};
            else
                result = val - 8'd1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 24h BCD clock: MODE/UP/DOWN editing, LOAD commit, idle timeout.
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat after REPEAT_DELAY ticks.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 30
`ifdef AUTO_REPEAT_EN
   ,parameter int REPEAT_DELAY  = 2
`endif
) (
    input  logic           CLK,
    input  logic           RESET,
    clock_set_ctrl_if.slave bus
);

    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

    state_t              state, next_state;
    logic                mode_q, up_q, down_q;
    logic                in_set, mode_ev, up_ev, down_ev;
    logic                step_ev, step_up, timeout_hit;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                phase;
    logic                run_en, load;
    time_t               load_val, edit_val, edit_next;
    logic [FIELD_W-1:0]  field_cur, field_lim, field_new;
    logic [2:0]          blink_mask;

    assign in_set  = (state != ST_RUN);
    assign mode_ev = bus.BTN_MODE & ~mode_q;
    // UP/DOWN edges lose to MODE and cancel each other when simultaneous.
    assign up_ev   = in_set & bus.BTN_UP & ~up_q & ~mode_ev & ~(bus.BTN_DOWN & ~down_q);
    assign down_ev = in_set & bus.BTN_DOWN & ~down_q & ~mode_ev & ~(bus.BTN_UP & ~up_q);

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    logic [REP_W-1:0] rep_cnt;
    logic             held, rep_step;

    assign held = in_set & ~mode_ev &
                  ((bus.BTN_UP & up_q & ~bus.BTN_DOWN) | (bus.BTN_DOWN & down_q & ~bus.BTN_UP));
    assign rep_step = held & bus.TICK & (rep_cnt == REP_W'(REPEAT_DELAY));

    always_ff @(posedge CLK) begin
        if (!RESET || !held)
            rep_cnt <= '0;
        else if (bus.TICK && rep_cnt != REP_W'(REPEAT_DELAY))
            rep_cnt <= rep_cnt + 1'b1;
    end

    assign step_ev = up_ev | down_ev | rep_step;
    assign step_up = up_ev | (rep_step & bus.BTN_UP);
`else
    assign step_ev = up_ev | down_ev;
    assign step_up = up_ev;
`endif

    assign timeout_hit = in_set & bus.TICK & ~mode_ev & ~step_ev &
                         (idle_cnt == IDLE_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= ST_RUN;
            run_en <= 1'b1;
        end else begin
            state  <= next_state;
            run_en <= (next_state == ST_RUN);
        end
    end

    always_comb begin
        next_state = state;
        if (mode_ev) begin
            case (state)
                ST_RUN:   next_state = ST_SET_H;
                ST_SET_H: next_state = ST_SET_M;
                ST_SET_M: next_state = ST_SET_S;
                default:  next_state = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            next_state = ST_RUN;
        end
    end

    always_comb begin
        blink_mask = '0;
        field_lim  = MS_MAX;
        field_cur  = edit_val[S_LSB +: FIELD_W];
        edit_next  = edit_val;
        case (state)
            ST_SET_H: begin
                blink_mask = {phase, 2'b00};
                field_lim  = H_MAX;
                field_cur  = edit_val[H_LSB +: FIELD_W];
                edit_next[H_LSB +: FIELD_W] = field_new;
            end
            ST_SET_M: begin
                blink_mask = {1'b0, phase, 1'b0};
                field_cur  = edit_val[M_LSB +: FIELD_W];
                edit_next[M_LSB +: FIELD_W] = field_new;
            end
            ST_SET_S: begin
                blink_mask = {2'b00, phase};
                edit_next[S_LSB +: FIELD_W] = field_new;
            end
            default: ;
        endcase
    end

    bcd_field_step u_step (
        .val    (field_cur),
        .limit  (field_lim),
        .up     (step_up),
        .result (field_new)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mode_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            idle_cnt <= '0;
            phase    <= 1'b0;
            load     <= 1'b0;
            load_val <= '0;
            edit_val <= '0;
        end else begin
            mode_q <= bus.BTN_MODE;
            up_q   <= bus.BTN_UP;
            down_q <= bus.BTN_DOWN;

            load <= (state == ST_SET_S) && mode_ev;
            if ((state == ST_SET_S) && mode_ev)
                load_val <= edit_val;

            if ((state == ST_RUN) && mode_ev)
                edit_val <= bus.CUR_TIME;
            else if (step_ev)
                edit_val <= edit_next;

            if ((next_state != state) || step_ev || !in_set)
                idle_cnt <= '0;
            else if (bus.TICK)
                idle_cnt <= idle_cnt + 1'b1;

            if ((next_state != state) || !in_set)
                phase <= 1'b0;
            else if (bus.TICK)
                phase <= ~phase;
        end
    end

    assign bus.RUN_EN     = run_en;
    assign bus.LOAD       = load;
    assign bus.LOAD_VAL   = load_val;
    assign bus.EDIT_VAL   = edit_val;
    assign bus.BLINK_MASK = blink_mask;
    assign bus.MODE_STATE = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (default build, TIMEOUT_TICKS=30).
module tb_clock_set_ctrl;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    int   load_cnt;

    clock_set_ctrl_if bus();

    clock_set_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.LOAD === 1'b1)
            load_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        bus.BTN_MODE = m;
        bus.BTN_UP   = u;
        bus.BTN_DOWN = d;
        cyc(1);
        bus.BTN_MODE = 1'b0;
        bus.BTN_UP   = 1'b0;
        bus.BTN_DOWN = 1'b0;
        cyc(1);
    endtask

    task automatic tick_pulse();
        bus.TICK = 1'b1;
        cyc(1);
        bus.TICK = 1'b0;
        cyc(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        load_cnt = 0;
        RESET        = 1'b0;
        bus.TICK     = 1'b0;
        bus.BTN_MODE = 1'b0;
        bus.BTN_UP   = 1'b0;
        bus.BTN_DOWN = 1'b0;
        bus.CUR_TIME = 24'h000000;
        cyc(3);
        RESET = 1'b1;
        cyc(1);

        chk("rst_run_en",  32'(bus.RUN_EN),     32'h1);
        chk("rst_load",    32'(bus.LOAD),       32'h0);
        chk("rst_state",   32'(bus.MODE_STATE), 32'h0);
        chk("rst_blink",   32'(bus.BLINK_MASK), 32'h0);
        chk("rst_edit",    32'(bus.EDIT_VAL),   32'h0);
        chk("rst_loadval", 32'(bus.LOAD_VAL),   32'h0);

        // Capture and hour wrap
        bus.CUR_TIME = 24'h235958;
        press(1'b1, 1'b0, 1'b0);
        chk("cap_edit",   32'(bus.EDIT_VAL),   32'h235958);
        chk("cap_state",  32'(bus.MODE_STATE), 32'h1);
        chk("cap_run_en", 32'(bus.RUN_EN),     32'h0);
        chk("cap_blink",  32'(bus.BLINK_MASK), 32'h0);
        press(1'b0, 1'b1, 1'b0);
        chk("h_up_wrap",  32'(bus.EDIT_VAL),   32'h005958);
        tick_pulse();
        chk("blink_h",    32'(bus.BLINK_MASK), 32'h4);

        // Minutes wrap both ways
        press(1'b1, 1'b0, 1'b0);
        chk("setm_state", 32'(bus.MODE_STATE), 32'h2);
        chk("setm_blink", 32'(bus.BLINK_MASK), 32'h0);
        press(1'b0, 1'b1, 1'b0);
        chk("m_up_wrap",  32'(bus.EDIT_VAL),   32'h000058);
        press(1'b0, 1'b0, 1'b1);
        chk("m_dn_wrap",  32'(bus.EDIT_VAL),   32'h005958);
        press(1'b0, 1'b0, 1'b1);
        chk("m_dn",       32'(bus.EDIT_VAL),   32'h005858);
        tick_pulse();
        chk("blink_m",    32'(bus.BLINK_MASK), 32'h2);

        // Seconds edit and commit
        press(1'b1, 1'b0, 1'b0);
        chk("sets_state", 32'(bus.MODE_STATE), 32'h3);
        press(1'b0, 1'b1, 1'b0);
        chk("s_up",       32'(bus.EDIT_VAL),   32'h005859);
        press(1'b0, 1'b1, 1'b0);
        chk("s_up_wrap",  32'(bus.EDIT_VAL),   32'h005800);
        press(1'b0, 1'b0, 1'b1);
        chk("s_dn_wrap",  32'(bus.EDIT_VAL),   32'h005859);
        press(1'b1, 1'b0, 1'b0);
        chk("commit1_cnt", 32'(load_cnt),      32'd1);
        chk("commit1_val", 32'(bus.LOAD_VAL),  32'h005859);
        chk("commit1_run", 32'(bus.RUN_EN),    32'h1);

        // Full MODE cycle with exact LOAD timing
        bus.CUR_TIME = 24'h120000;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("full_edit",  32'(bus.EDIT_VAL),   32'h120000);
        bus.BTN_MODE = 1'b1;
        cyc(1);
        chk("full_load_hi",  32'(bus.LOAD),       32'h1);
        chk("full_loadval",  32'(bus.LOAD_VAL),   32'h120000);
        chk("full_state",    32'(bus.MODE_STATE), 32'h0);
        bus.BTN_MODE = 1'b0;
        cyc(1);
        chk("full_load_lo",  32'(bus.LOAD),       32'h0);
        chk("full_run_en",   32'(bus.RUN_EN),     32'h1);
        cyc(3);
        chk("full_load_cnt", 32'(load_cnt),       32'd2);

        // Hours and seconds decrement wrap from zero
        bus.CUR_TIME = 24'h000000;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("h_dn_wrap",  32'(bus.EDIT_VAL),   32'h230000);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("s_dn_zero",  32'(bus.EDIT_VAL),   32'h230059);
        press(1'b1, 1'b0, 1'b0);
        chk("commit3_val", 32'(bus.LOAD_VAL),  32'h230059);
        chk("commit3_cnt", 32'(load_cnt),      32'd3);

        // Timeout from SET_H
        bus.CUR_TIME = 24'h101010;
        press(1'b1, 1'b0, 1'b0);
        repeat (29) tick_pulse();
        chk("to_not_yet", 32'(bus.MODE_STATE), 32'h1);
        tick_pulse();
        chk("to_state",   32'(bus.MODE_STATE), 32'h0);
        chk("to_run_en",  32'(bus.RUN_EN),     32'h1);
        chk("to_loadval", 32'(bus.LOAD_VAL),   32'h230059);
        chk("to_no_load", 32'(load_cnt),       32'd3);
        chk("to_blink",   32'(bus.BLINK_MASK), 32'h0);
        press(1'b0, 1'b1, 1'b0);
        chk("run_up_ign", 32'(bus.EDIT_VAL),   32'h101010);

        // Hour BCD carry, priority rules, reset mid-edit
        bus.CUR_TIME = 24'h080000;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("h_bcd_carry", 32'(bus.EDIT_VAL),  32'h100000);
        press(1'b1, 1'b1, 1'b0);
        chk("prio_state", 32'(bus.MODE_STATE), 32'h2);
        chk("prio_edit",  32'(bus.EDIT_VAL),   32'h100000);
        press(1'b0, 1'b1, 1'b1);
        chk("updn_ign",   32'(bus.EDIT_VAL),   32'h100000);
        press(1'b0, 1'b1, 1'b0);
        chk("m_up",       32'(bus.EDIT_VAL),   32'h100100);
        RESET = 1'b0;
        cyc(1);
        RESET = 1'b1;
        cyc(1);
        chk("mrst_state",   32'(bus.MODE_STATE), 32'h0);
        chk("mrst_edit",    32'(bus.EDIT_VAL),   32'h0);
        chk("mrst_run_en",  32'(bus.RUN_EN),     32'h1);
        chk("mrst_loadval", 32'(bus.LOAD_VAL),   32'h0);
        chk("mrst_no_load", 32'(load_cnt),       32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
